// File: rtl/tx_sym_pkg.sv
// Shared TX symbol definitions: ordered-set control characters, FSM states, symbol type.
// Also imported by the scrambler/descrambler so COM/SKP stay consistent along the link.
package tx_sym_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;

  typedef enum logic {PASS, SKP} skp_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
  } tx_sym_t;

  function automatic tx_sym_t mk_sym(input logic [7:0] data, input logic k);
    tx_sym_t s;
    s.data = data;
    s.k    = k;
    return s;
  endfunction

endpackage

// File: rtl/skp_interval_timer.sv
// Free-running 0..SKP_INTERVAL-1 counter; tick is high for the terminal-count cycle.
module skp_interval_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [W-1:0] TERM = W'(SKP_INTERVAL - 1);

  logic [W-1:0] count_q, count_d;

  assign tick = (count_q == TERM);

  always_comb begin
    count_d = tick ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/tx_skp_inserter.sv
// Merges the packet byte stream with periodic COM+SKP ordered sets, idle fill in gaps.
// Optional statistics ports are built when TX_SKP_STATS_EN is defined.
module tx_skp_inserter
  import tx_sym_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_NUM      = 3,
  parameter logic [7:0]  IDLE_DATA    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_k,
  input  logic       in_eop,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       skp_overrun
`ifdef TX_SKP_STATS_EN
  ,
  output logic [15:0] skp_sets,
  output logic [15:0] idle_cycles
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(SKP_NUM - 1);

  skp_state_e state_q, state_d;
  logic [2:0] skp_idx_q, skp_idx_d;
  logic       pending_q, pending_d;
  logic       in_pkt_q, in_pkt_d;
  logic       overrun_q, overrun_d;
  tx_sym_t    sym_q, sym_d;
  logic       tick;
  logic       insert_now;
  logic       emit_com;
  logic       emit_idle;

  skp_interval_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Ordered sets only start between packets, never while one is in flight.
  assign insert_now = pending_q & ~in_pkt_q & (state_q == PASS);
  assign in_ready   = ~rst & (state_q == PASS) & ~insert_now;

  always_comb begin
    state_d   = state_q;
    skp_idx_d = skp_idx_q;
    in_pkt_d  = in_pkt_q;
    sym_d     = mk_sym(IDLE_DATA, 1'b0);
    emit_com  = 1'b0;
    emit_idle = 1'b0;
    case (state_q)
      PASS: begin
        if (insert_now) begin
          sym_d     = mk_sym(K_COM, 1'b1);
          skp_idx_d = '0;
          state_d   = SKP;
          emit_com  = 1'b1;
        end else if (in_valid) begin
          sym_d    = mk_sym(in_data, in_k);
          in_pkt_d = ~in_eop;
        end else begin
          emit_idle = 1'b1;
        end
      end
      SKP: begin
        sym_d     = mk_sym(K_SKP, 1'b1);
        skp_idx_d = skp_idx_q + 3'd1;
        if (skp_idx_q == LAST_IDX) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  // A tick coinciding with COM becomes a fresh request rather than an overrun.
  always_comb begin
    pending_d = tick | (pending_q & ~emit_com);
    overrun_d = overrun_q | (tick & pending_q & ~emit_com);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PASS;
      skp_idx_q <= '0;
      pending_q <= 1'b0;
      in_pkt_q  <= 1'b0;
      overrun_q <= 1'b0;
      sym_q     <= mk_sym(8'h00, 1'b0);
    end else begin
      state_q   <= state_d;
      skp_idx_q <= skp_idx_d;
      pending_q <= pending_d;
      in_pkt_q  <= in_pkt_d;
      overrun_q <= overrun_d;
      sym_q     <= sym_d;
    end
  end

  assign data_out    = sym_q.data;
  assign k_out       = sym_q.k;
  assign skp_overrun = overrun_q;

`ifdef TX_SKP_STATS_EN
  logic [15:0] sets_q, sets_d;
  logic [15:0] idle_q, idle_d;

  always_comb begin
    sets_d = emit_com ? sets_q + 16'd1 : sets_q;
    idle_d = (emit_idle && idle_q != 16'hFFFF) ? idle_q + 16'd1 : idle_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sets_q <= '0;
      idle_q <= '0;
    end else begin
      sets_q <= sets_d;
      idle_q <= idle_d;
    end
  end

  assign skp_sets    = sets_q;
  assign idle_cycles = idle_q;
`endif

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Randomized and directed bench for tx_skp_inserter against a cycle-level behavioural model.
// Statistics checks are compiled in when TX_SKP_STATS_EN is defined.
module tb_tx_skp_inserter;

  localparam int INTERVAL = 16;
  localparam int NUM      = 3;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_k;
  logic       in_eop;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       k_out;
  logic       skp_overrun;
`ifdef TX_SKP_STATS_EN
  logic [15:0] skp_sets;
  logic [15:0] idle_cycles;
`endif

  tx_skp_inserter #(
    .SKP_INTERVAL(INTERVAL),
    .SKP_NUM     (NUM),
    .IDLE_DATA   (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_k       (in_k),
    .in_eop     (in_eop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .k_out      (k_out),
    .skp_overrun(skp_overrun)
`ifdef TX_SKP_STATS_EN
    ,
    .skp_sets   (skp_sets),
    .idle_cycles(idle_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset, request flag, sticky overrun, packet open, SKPs still owed.
  int m_t;
  bit m_req, m_ovr, m_pkt;
  int m_os;
  int m_sets, m_idles;

  logic [8:0] hist[$];
  bit         ready_hist[$];
  bit         last_acc;
  int         cyc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_req = 0; m_ovr = 0; m_pkt = 0; m_os = 0; m_sets = 0; m_idles = 0;
    hist.delete(); ready_hist.delete(); cyc = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_k = 1'b0; in_eop = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_val("rst_data", {24'd0, data_out}, 32'd0);
    check_val("rst_k", {31'd0, k_out}, 32'd0);
    check_val("rst_ovr", {31'd0, skp_overrun}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, predict, let the edge happen, compare the registered outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit k, input bit e);
    bit         exp_ready, tick, com;
    logic [8:0] exp_sym;
    in_valid = v; in_data = d; in_k = k; in_eop = e;
    #1;
    exp_ready = (m_os == 0) && !(m_req && !m_pkt);
    tick = (m_t == INTERVAL - 1);
    com = 0;
    last_acc = 0;
    if (m_os > 0) begin
      exp_sym = {8'h1C, 1'b1}; m_os--;
    end else if (m_req && !m_pkt) begin
      exp_sym = {8'hBC, 1'b1}; m_os = NUM; com = 1; m_sets++;
    end else if (v) begin
      exp_sym = {d, k}; last_acc = 1; m_pkt = !e;
    end else begin
      exp_sym = {8'h00, 1'b0};
      if (m_idles < 65535) m_idles++;
    end
    if (tick && m_req && !com) m_ovr = 1;
    if (tick) m_req = 1;
    else if (com) m_req = 0;
    m_t = (m_t + 1) % INTERVAL;
    check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    ready_hist.push_back(in_ready);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_val("sym", {23'd0, data_out, k_out}, {23'd0, exp_sym});
    check_val("overrun", {31'd0, skp_overrun}, {31'd0, m_ovr});
`ifdef TX_SKP_STATS_EN
    check_val("skp_sets", {16'd0, skp_sets}, 32'(m_sets & 32'hFFFF));
    check_val("idle_cycles", {16'd0, idle_cycles}, 32'(m_idles));
`endif
    hist.push_back({data_out, k_out});
  endtask

  // Present one beat, holding it until accepted.
  task automatic send_beat(input logic [7:0] d, input bit k, input bit e);
    int tries = 0;
    do begin
      step(1'b1, d, k, e);
      tries++;
    end while (!last_acc && tries < 40);
    if (!last_acc) check_val("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_idx, zeros, coms, len;
    logic [7:0] d;
    bit k;

    // Long packet: request deferred past eop, overlapping request raises overrun.
    do_reset(2);
    for (int i = 0; i < 40; i++) send_beat(8'(i), 1'b0, i == 39);
    e_idx = cyc;
    repeat (12) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) check_val("pkt_byte", {23'd0, hist[i]}, {23'd0, 8'(i), 1'b0});
    zeros = 0;
    for (int i = e_idx; i < e_idx + 6; i++) if (!ready_hist[i]) zeros++;
    check_val("ready_low_cycles", 32'(zeros), 32'd4);
    coms = 0;
    for (int i = e_idx; i < e_idx + 8; i++) if (hist[i] == {8'hBC, 1'b1}) coms++;
    check_val("os_after_eop", 32'(coms), 32'd1);
    check_val("ovr_set", {31'd0, skp_overrun}, 32'd1);
    repeat (20) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("ovr_sticky", {31'd0, skp_overrun}, 32'd1);

    // Reset in the middle of an ordered set.
    do_reset(2);
    repeat (19) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("pre_abort_skp", {23'd0, hist[18]}, {23'd0, 8'h1C, 1'b1});
    do_reset(1);
    repeat (20) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("abort_first", {23'd0, hist[0]}, {23'd0, 8'h00, 1'b0});
    check_val("abort_pre_com", {23'd0, hist[15]}, {23'd0, 8'h00, 1'b0});
    check_val("abort_com", {23'd0, hist[16]}, {23'd0, 8'hBC, 1'b1});
    check_val("abort_ovr", {31'd0, skp_overrun}, 32'd0);

    // Random packets with random gaps.
    do_reset(2);
    while (cyc < 2000) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        d = 8'($urandom);
        k = ($urandom_range(0, 15) == 0);
        if (k && (d == 8'hBC || d == 8'h1C)) d = 8'hF7;
        send_beat(d, k, b == len - 1);
      end
      if ($urandom_range(0, 1) == 0)
        repeat ($urandom_range(1, 6)) step(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Idle stream after reset.
    do_reset(2);
    repeat (100) step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check_val("idle_start", {23'd0, hist[i]}, {23'd0, 8'h00, 1'b0});
    check_val("first_com", {23'd0, hist[16]}, {23'd0, 8'hBC, 1'b1});
    for (int i = 17; i < 20; i++) check_val("first_skp", {23'd0, hist[i]}, {23'd0, 8'h1C, 1'b1});
    check_val("after_os", {23'd0, hist[20]}, {23'd0, 8'h00, 1'b0});
    check_val("second_com", {23'd0, hist[32]}, {23'd0, 8'hBC, 1'b1});
    check_val("idle_ovr", {31'd0, skp_overrun}, 32'd0);
`ifdef TX_SKP_STATS_EN
    check_val("stats_sets_100", {16'd0, skp_sets}, 32'd6);
    check_val("stats_idle_100", {16'd0, idle_cycles}, 32'd76);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
